// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: FSM state encoding and source-ID sizing helper shared by the stream arbiter files
package stream_arb_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: bundle of N source streams and one merged destination stream
//   src_valid/src_data/src_last/src_ready : per-source handshake, source i at src_data[i*WIDTH +: WIDTH]
//   dst_valid/dst_data/dst_last/dst_id/dst_ready : merged output with originating source index
//   busy : high while a packet grant is held
//   master drives the sources and dst_ready, slave is the arbiter
interface stream_rr_arbiter_if
   import stream_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int IDW   = idw_of(N)
) ();
   logic [N-1:0]       src_valid;
   logic [N*WIDTH-1:0] src_data;
   logic [N-1:0]       src_last;
   logic [N-1:0]       src_ready;
   logic               dst_valid;
   logic [WIDTH-1:0]   dst_data;
   logic               dst_last;
   logic [IDW-1:0]     dst_id;
   logic               dst_ready;
   logic               busy;
   modport master (
      output src_valid, src_data, src_last, dst_ready,
      input  src_ready, dst_valid, dst_data, dst_last, dst_id, busy
   );
   modport slave (
      input  src_valid, src_data, src_last, dst_ready,
      output src_ready, dst_valid, dst_data, dst_last, dst_id, busy
   );
endinterface

// File: rtl/fwd_reg_slice.sv
// fwd_reg_slice: forward-registered pipeline slice, one beat of storage, full throughput
//   clk, s_rst : clock, synchronous active-high reset
//   in_valid, in_payload : beat offered to the slice (only when can_accept is high)
//   can_accept : slice is empty or its beat is leaving this cycle
//   out_valid, out_payload, out_ready : registered output handshake
module fwd_reg_slice #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          s_rst,
   input  logic          in_valid,
   input  logic [PW-1:0] in_payload,
   output logic          can_accept,
   output logic          out_valid,
   output logic [PW-1:0] out_payload,
   input  logic          out_ready
);
   assign can_accept = !out_valid || out_ready;
   always_ff @(posedge clk) begin
      if (s_rst) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
      end else if (can_accept) begin
         out_valid <= in_valid;
         if (in_valid) out_payload <= in_payload;
      end
   end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-level round-robin merge of N streams into one registered output stream
//   clk, s_rst : clock, synchronous active-high reset
//   bus (slave) : src_* inputs with src_ready, dst_* output with dst_id, dst_ready input, busy
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int IDW   = idw_of(N)
) (
   input logic               clk,
   input logic               s_rst,
   stream_rr_arbiter_if.slave bus
);
   localparam int PW = WIDTH + 1 + IDW;
   arb_state_t       state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt, grant, grant_nxt, pick, grant_inc;
   logic             can_accept, accept, last_acc;
   logic [PW-1:0]    slice_in, slice_out;
   logic [WIDTH-1:0] data_arr [N];
   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign data_arr[g] = bus.src_data[g*WIDTH +: WIDTH];
   end
   function automatic logic [IDW-1:0] wrap(input int v);
      return IDW'(v % N);
   endfunction
   // Scan offsets high to low so the smallest offset from ptr with valid set wins.
   always_comb begin
      pick = ptr;
      for (int k = N - 1; k >= 0; k--)
         if (bus.src_valid[wrap(int'(ptr) + k)]) pick = wrap(int'(ptr) + k);
   end
   assign grant_inc = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
   assign accept    = (state == GRANT) && bus.src_valid[grant] && can_accept;
   assign last_acc  = accept && bus.src_last[grant];
   always_ff @(posedge clk) begin
      if (s_rst) begin
         state <= IDLE;
         ptr   <= '0;
         grant <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
      end
   end
   always_comb begin
      state_nxt = (state == IDLE) ? ((|bus.src_valid) ? GRANT : IDLE) : (last_acc ? IDLE : GRANT);
      grant_nxt = (state == IDLE && |bus.src_valid) ? pick : grant;
      ptr_nxt   = last_acc ? grant_inc : ptr;
   end
   always_comb begin
      bus.src_ready = (state == GRANT && can_accept) ? (N'(1) << grant) : '0;
      bus.busy      = state == GRANT;
   end
   assign slice_in = {data_arr[grant], bus.src_last[grant], grant};
   fwd_reg_slice #(.PW(PW)) u_slice (
      .clk         (clk),
      .s_rst       (s_rst),
      .in_valid    (accept),
      .in_payload  (slice_in),
      .can_accept  (can_accept),
      .out_valid   (bus.dst_valid),
      .out_payload (slice_out),
      .out_ready   (bus.dst_ready)
   );
   assign {bus.dst_data, bus.dst_last, bus.dst_id} = slice_out;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: randomized scoreboard bench plus directed reset/re-grant scenarios
module tb_stream_rr_arbiter;
   localparam int W = 8, N = 4, IDW = 2;
   typedef struct packed {logic [7:0] d; logic l; logic f;} beat_t;
   typedef struct packed {logic [7:0] d; logic l; logic [1:0] id;} obeat_t;
   logic clk = 1'b0;
   logic s_rst = 1'b1;
   stream_rr_arbiter_if #(.WIDTH(W), .N(N), .IDW(IDW)) bus ();
   stream_rr_arbiter #(.WIDTH(W), .N(N), .IDW(IDW)) dut (.clk(clk), .s_rst(s_rst), .bus(bus.slave));
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   bit auto_en = 1'b0;
   beat_t src_q [N][$];
   beat_t mq [N][$];
   obeat_t exp_q[$];
   int acc_q[$];
   int pk_total = 0, pk_done = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_reset();
      chk("rst_dst_valid", bus.dst_valid, 0);
      chk("rst_dst_data", bus.dst_data, 0);
      chk("rst_dst_last", bus.dst_last, 0);
      chk("rst_dst_id", bus.dst_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_src_ready", bus.src_ready, 0);
   endtask
   // One-beat directed transfer from IDLE: one arbitration cycle, then accept, then output next cycle.
   task automatic offer(input int i, input logic [7:0] d, input logic l);
      int n = 0;
      bus.src_valid[i] = 1'b1;
      bus.src_data[i*W +: W] = d;
      bus.src_last[i] = l;
      @(negedge clk);
      chk($sformatf("arb_wait_src%0d", i), bus.src_ready, 0);
      while (!bus.src_ready[i] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("arb_cycles_src%0d", i), n, 1);
      @(posedge clk);
      #1;
      bus.src_valid[i] = 1'b0;
      chk("dir_data", bus.dst_data, d);
      chk("dir_id", bus.dst_id, i);
      chk("dir_last", bus.dst_last, l);
      chk("dir_valid", bus.dst_valid, 1);
   endtask
   // Source driver: first beats are offered immediately, later beats may be delayed; held until accepted.
   initial begin
      bit acc [N];
      int phase;
      beat_t b;
      phase = 0;
      foreach (acc[i]) acc[i] = 1'b0;
      forever begin
         @(negedge clk);
         if (auto_en) begin
            if (phase == 1) begin
               chk("gap_busy", bus.busy, 0);
               chk("gap_ready", bus.src_ready, 0);
               phase = 2;
            end else if (phase == 2) begin
               chk("regrant_busy", bus.busy, pk_done < pk_total);
               phase = 0;
            end
            for (int i = 0; i < N; i++) begin
               acc[i] = bus.src_valid[i] && bus.src_ready[i];
               if (acc[i] && src_q[i].size() > 0) begin
                  chk("accept_src", i, (acc_q.size() > 0) ? acc_q[0] : -1);
                  if (acc_q.size() > 0) void'(acc_q.pop_front());
                  b = src_q[i].pop_front();
                  if (b.l) begin
                     pk_done++;
                     phase = 1;
                  end
               end
            end
         end
         @(posedge clk);
         #1;
         if (auto_en) begin
            for (int i = 0; i < N; i++) begin
               if (src_q[i].size() == 0) begin
                  bus.src_valid[i] = 1'b0;
                  bus.src_last[i]  = 1'b0;
               end else if (!(bus.src_valid[i] && !acc[i])) begin
                  b = src_q[i][0];
                  bus.src_valid[i] = b.f || ($urandom_range(0, 2) != 0);
                  bus.src_data[i*W +: W] = b.d;
                  bus.src_last[i] = b.l;
               end
            end
            bus.dst_ready = $urandom_range(0, 3) != 0;
         end
      end
   end
   // Output monitor: every valid output cycle must show the scoreboard head; pop on handshake.
   initial forever begin
      @(negedge clk);
      if (auto_en && bus.dst_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got data %0h id %0h, want none", bus.dst_data, bus.dst_id);
         end else begin
            chk("dst_data", bus.dst_data, exp_q[0].d);
            chk("dst_last", bus.dst_last, exp_q[0].l);
            chk("dst_id", bus.dst_id, exp_q[0].id);
            if (bus.dst_ready) void'(exp_q.pop_front());
         end
      end
   end
   initial begin
      int n, mptr, pick, len, npk;
      beat_t b;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.src_last  = '0;
      bus.dst_ready = 1'b1;
      s_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      s_rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         npk = $urandom_range(1, 5);
         for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
               b.d = 8'($urandom);
               b.l = (k == len - 1);
               b.f = (k == 0);
               src_q[i].push_back(b);
               mq[i].push_back(b);
            end
            pk_total++;
         end
      end
      // Reference order: every source with packets left is requesting at each arbitration point,
      // so each packet goes to the first such source at or after the rotating pointer.
      mptr = 0;
      for (int p = 0; p < pk_total; p++) begin
         pick = -1;
         for (int k = 0; k < N; k++)
            if (pick < 0 && mq[(mptr + k) % N].size() > 0) pick = (mptr + k) % N;
         do begin
            b = mq[pick].pop_front();
            exp_q.push_back({b.d, b.l, 2'(pick)});
            acc_q.push_back(pick);
         end while (!b.l);
         mptr = (pick + 1) % N;
      end
      auto_en = 1'b1;
      n = 0;
      while ((exp_q.size() > 0 || pk_done < pk_total) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("FAIL random_timeout: %0d beats left, want 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      auto_en = 1'b0;
      bus.src_valid = '0;
      bus.src_last  = '0;
      bus.dst_ready = 1'b1;
      offer(1, 8'h51, 1'b1);
      offer(2, 8'h71, 1'b1);
      offer(2, 8'h72, 1'b1);
      offer(3, 8'hA1, 1'b0);
      bus.src_valid[3] = 1'b1;
      bus.src_data[3*W +: W] = 8'hA2;
      s_rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset();
      s_rst = 1'b0;
      bus.src_valid = '0;
      bus.src_valid[1] = 1'b1;
      bus.src_data[1*W +: W] = 8'h61;
      bus.src_last[1] = 1'b1;
      bus.src_valid[3] = 1'b1;
      bus.src_data[3*W +: W] = 8'h63;
      bus.src_last[3] = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", bus.src_ready, 0);
      @(negedge clk);
      chk("post_rst_grant", bus.src_ready, 4'b0010);
      @(posedge clk);
      #1;
      bus.src_valid[1] = 1'b0;
      chk("post_rst_id1", bus.dst_id, 1);
      chk("post_rst_data1", bus.dst_data, 8'h61);
      @(negedge clk);
      chk("post_rst_gap", bus.src_ready, 0);
      @(negedge clk);
      chk("post_rst_grant3", bus.src_ready, 4'b1000);
      @(posedge clk);
      #1;
      bus.src_valid[3] = 1'b0;
      chk("post_rst_id3", bus.dst_id, 3);
      chk("post_rst_data3", bus.dst_data, 8'h63);
      chk("post_rst_last3", bus.dst_last, 1);
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits.
REQ-002 Parameter N, default 4, number of source streams (2..16).
REQ-003 Parameter IDW, default clog2(N), width of source-ID field.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 s_rst  in  1  reset, synchronous, active-high.
REQ-006 src_valid  in  N  per-source beat valid.
REQ-007 src_data  in  N*WIDTH  per-source payload; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 src_last  in  N  per-source end-of-packet marker.
REQ-009 src_ready  out  N  per-source beat accept.
REQ-010 dst_valid  out  1  output beat valid.
REQ-011 dst_data  out  WIDTH  output payload.
REQ-012 dst_last  out  1  output end-of-packet.
REQ-013 dst_id  out  IDW  index of the source that produced the output beat.
REQ-014 dst_ready  in  1  downstream accept.
REQ-015 busy  out  1  high while a packet grant is held (state GRANT).

Function
REQ-016 A beat transfers on any port when valid and ready are both high at a clock edge; src_valid/data/last are held stable by sources until accepted.
REQ-017 FSM has two states: IDLE (no grant) and GRANT (one source owns the output).
REQ-018 In IDLE with any src_valid high, the next state is GRANT with grant = the first i with src_valid[i]=1, searching ptr, ptr+1, ... mod N; with no src_valid high, the FSM stays in IDLE.
REQ-019 src_ready is all-zero in IDLE; arbitration costs exactly one cycle (the first beat is accepted no earlier than one cycle after src_valid rises).
REQ-020 In GRANT, src_ready[grant] = slice_can_accept, where slice_can_accept = !dst_valid | dst_ready; every other src_ready bit is 0.
REQ-021 The output is a forward-registered slice: an accepted beat appears on dst_valid/data/last/id on the next cycle, and back-to-back beats sustain 1 beat/cycle while dst_ready=1.
REQ-022 If dst_valid=1 and dst_ready=0, then dst_data, dst_last and dst_id are held unchanged.
REQ-023 An accepted beat with src_last=1 from the granted source moves the FSM to IDLE and sets ptr to (grant+1) mod N on the same edge.
REQ-024 The grant is never changed mid-packet, regardless of the other sources' src_valid.
REQ-025 Between consecutive packets the arbiter inserts exactly one idle arbitration cycle, including re-grant to the same source.
REQ-026 If the granted source deasserts src_valid mid-packet, the grant is held; no timeout applies.
REQ-027 ptr wraps from N-1 to 0; when N is not a power of two, grant and ptr values >= N never occur.
REQ-028 busy=1 exactly when state=GRANT.

Reset
REQ-029 While s_rst=1: state=IDLE, ptr=0, grant=0, and src_ready=0, dst_valid=0, dst_data=0, dst_last=0, dst_id=0, busy=0 at the next edge.
REQ-030 A reset asserted mid-packet discards the in-flight slice contents and the grant; after reset release, arbitration restarts at ptr=0.

Structure
REQ-031 Package stream_arb_pkg holds the FSM state encoding (IDLE=0, GRANT=1) and the clog2-based IDW helper.
REQ-032 Sub-module fwd_reg_slice (payload WIDTH+1+IDW bits: data, last, id) implements REQ-021/022 and exports slice_can_accept.

Verification
REQ-033 Single source 0 sends a 3-beat packet 0x11,0x22,0x33(last) with dst_ready=1 -> dst beats 0x11,0x22,0x33 on consecutive cycles, dst_id=0, dst_last on the third beat only, busy high 3 cycles.
REQ-034 All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0 with one idle cycle between packets.
REQ-035 Source 1 mid-packet while source 2 raises valid -> source 2 is not granted until source 1's last beat is accepted; next grant=2.
REQ-036 dst_ready held 0 for 5 cycles mid-packet -> dst_data/dst_id held stable, src_ready[grant]=0 after the slice fills, no beat lost or duplicated.
REQ-037 s_rst pulsed for 1 cycle during the 2nd beat of a packet from source 3 -> all outputs 0 next cycle; a subsequent request from source 3 is arbitrated from ptr=0.
REQ-038 Only source 2 streams two 1-beat packets -> grant=2 twice, separated by exactly one idle cycle (REQ-025).
